knight_rider_sequencer: RTL and testbench
=========================================

Name: knight_rider_sequencer

Overview:
Controller that sequences the 14-state one-hot ring used for the Knight Rider LED effect. It owns the ring register and a programmable step prescaler. It runs a start/pause/stop state machine and folds the 14 ring states onto an 8-bit LED bar (0→7→1) so the LEDs bounce in both directions. A valid/ready config port changes the step rate, but only at safe points.

Parameters:
RING_W, 14, ring length; fixed at 2*LED_W-2
LED_W, 8, LED bar width
DIV_W, 24, prescaler/divisor width
DEF_DIV, 24'd5_000_000, divisor after reset (clock cycles per step)
SWP_W, 16, sweep counter width

Ports:
clk_i  in  1  clock, all state on rising edge
sys_rst_i  in  1  asynchronous, active-low reset
start_i  in  1  start from IDLE / resume from PAUSE (level, sampled)
pause_i  in  1  freeze in place
stop_i  in  1  request stop
cfg_valid_i  in  1  divisor update valid
cfg_div_i  in  DIV_W  new divisor
cfg_ready_o  out  1  divisor update accepted when valid&ready
led_o  out  LED_W  one-hot LED pattern, 0 when IDLE
ring_o  out  RING_W  raw ring state
pos_o  out  4  ring index 0..13
dir_o  out  1  1 = moving toward LED7 (pos 0..6), 0 = toward LED0 (pos 7..13)
busy_o  out  1  state != IDLE
sweep_done_o  out  1  1-cycle pulse on ring wrap 13→0
sweep_cnt_o  out  SWP_W  completed full sweeps, saturating

Behaviour:
- Reset (sys_rst_i=0, async):
  - state=IDLE, ring=14'h0001, prescaler cnt=0, div_q=DEF_DIV, sweep_cnt=0.
  - Outputs: led_o=0, pos_o=0, dir_o=1, busy_o=0, sweep_done_o=0, cfg_ready_o=1.
- States:
  - IDLE→RUN on start_i. Entry clears ring to bit0, cnt=0 and sweep_cnt=0.
  - RUN→PAUSE on pause_i.
  - RUN→STOPPING on stop_i.
  - PAUSE→RUN on start_i (ring and cnt kept). PAUSE→IDLE on stop_i.
  - STOPPING→IDLE on the step that wraps ring 13→0. pause_i is ignored in STOPPING.
  - Priority: stop_i > pause_i > start_i.
- Prescaler:
  - div_eff = (div_q==0) ? 1 : div_q.
  - In RUN/STOPPING, cnt increments each cycle. step = (cnt==div_eff-1); on step, cnt←0.
  - cnt holds in PAUSE; cnt=0 in IDLE.
- Ring: on step, rotate left (bit13→bit0). The ring never changes in IDLE or PAUSE.
- LED map (combinational from ring): led index = pos≤7 ? pos : 14−pos. led_o is that one-hot, gated to 0 in IDLE.
- Latency:
  - start_i sampled at edge t → busy_o=1 and led_o=8'h01 after t.
  - First step occurs div_eff cycles later. One full sweep takes 14*div_eff cycles.
- Sweep:
  - On a step with pos=13: sweep_done_o=1 for that cycle+1 (registered).
  - sweep_cnt increments, saturating at all-ones.
- Config handshake:
  - cfg_ready_o=1 in IDLE and PAUSE. In RUN/STOPPING it is 1 only in the cycle where step&&pos==13.
  - On acceptance: div_q←cfg_div_i and cnt←0.
  - If valid is held without ready, the request waits; cfg_div_i must stay stable.
- Simultaneous events:
  - stop_i in the same cycle as a wrap step from RUN: go directly to IDLE.
  - Config acceptance coincident with a wrap step: the new divisor applies to the next step interval.
- Reset mid-sweep returns to the full reset values immediately.

Decomposition:
- knight_rider_pkg:
  - typedef enum {IDLE, RUN, PAUSE, STOPPING} kr_state_e
  - constants RING_W=14, LED_W=8
  - function ring_to_led(ring) returning the folded one-hot
- Sub-module kr_prescaler: cnt, div_eff, step, clear/hold/load inputs.
- FSM, ring and sweep logic stay in the top.

Test Plan:
- Reset, then cfg div=4 in IDLE, then start_i pulse:
  - led_o=01 for 4 cycles, then 02,04,08,10,20,40,80,40,20,10,08,04,02, each 4 cycles, then 01.
  - sweep_done_o pulses once after 56 cycles; sweep_cnt_o=1.
- Pause at led_o=10 for 20 cycles, then start_i:
  - pattern and remaining prescaler count resume exactly; no skipped or extra step.
- stop_i at pos=5 (div=4):
  - sweep continues to pos 13, wraps, then busy_o=0, led_o=0, ring_o=14'h0001.
  - stop_i asserted together with the wrap step gives IDLE the next cycle.
- cfg_valid_i div=2 mid-RUN at pos=3:
  - cfg_ready_o stays 0 until the pos13 wrap step; accepted there.
  - Next sweep steps every 2 cycles. div=0 behaves as div=1.
- sys_rst_i low at pos=9 for 1 cycle:
  - all outputs return to reset values asynchronously; start_i restarts from led_o=01.
- Force sweep_cnt near max (SWP_W=2 build): 3 sweeps → cnt=3; 4th sweep stays 3, sweep_done_o still pulses.

Source files
------------

// File: rtl/knight_rider_pkg.sv
// rtl/knight_rider_pkg.sv - shared types, constants and LED fold helper for the Knight Rider sequencer
//
// Purpose: ring/LED geometry constants, controller state encoding and the
//          combinational fold of the 14-state ring onto the 8-LED bar.
// Ports:   none (package).
package knight_rider_pkg;

  localparam int RING_W = 14;
  localparam int LED_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PAUSE    = 2'd2,
    STOPPING = 2'd3
  } kr_state_e;

  // Ring positions 0..7 light LEDs 0..7, positions 8..13 come back down 6..1,
  // so a single rotating bit bounces across the bar.
  function automatic logic [LED_W-1:0] ring_to_led(input logic [RING_W-1:0] ring);
    logic [LED_W-1:0] led;
    led = '0;
    for (int i = 0; i < RING_W; i++) begin
      int idx;
      idx = (i < LED_W) ? i : (RING_W - i);
      if (ring[i]) led[idx[2:0]] = 1'b1;
    end
    return led;
  endfunction

endpackage

// File: rtl/kr_prescaler.sv
// rtl/kr_prescaler.sv - programmable step prescaler with divisor register
//
// Purpose: counts clock cycles while running and emits a one-cycle step every
//          div_eff cycles; owns the divisor register (div 0 acts as div 1).
// Ports:   clk_i, rst_n_i    clock, async active-low reset
//          run_i             count this cycle (hold when low)
//          clear_i           force count to zero
//          load_i, load_div_i  load new divisor (also zeroes the count)
//          step_o            combinational step strobe
module kr_prescaler
  import knight_rider_pkg::*;
#(
  parameter int                DIV_W   = 24,
  parameter logic [DIV_W-1:0]  DEF_DIV = 24'd5_000_000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_div_i,
  output logic             step_o
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_eff;

  always_comb begin
    div_eff = (div_q == '0) ? ONE : div_q;
    step_o  = run_i && (cnt_q == (div_eff - ONE));
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (load_i) div_d = load_div_i;
    // A new divisor restarts the interval so it never sees a stale count.
    if (clear_i || load_i) cnt_d = '0;
    else if (run_i)        cnt_d = step_o ? '0 : (cnt_q + ONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      div_q <= DEF_DIV;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/knight_rider_sequencer.sv
// rtl/knight_rider_sequencer.sv - Knight Rider ring sequencer with start/pause/stop control
//
// Purpose: owns the 14-state one-hot ring, steps it from the prescaler, runs the
//          IDLE/RUN/PAUSE/STOPPING controller, folds the ring onto the LED bar
//          and counts completed sweeps; divisor updates only at safe points.
// Ports:   clk_i, sys_rst_i             clock, async active-low reset
//          start_i, pause_i, stop_i     control levels (stop > pause > start)
//          cfg_valid_i, cfg_div_i, cfg_ready_o  divisor update handshake
//          led_o, ring_o, pos_o, dir_o  display outputs
//          busy_o, sweep_done_o, sweep_cnt_o  status
module knight_rider_sequencer
  import knight_rider_pkg::*;
#(
  parameter int               DIV_W   = 24,
  parameter logic [DIV_W-1:0] DEF_DIV = 24'd5_000_000,
  parameter int               SWP_W   = 16
) (
  input  logic              clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              stop_i,
  input  logic              cfg_valid_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic              cfg_ready_o,
  output logic [LED_W-1:0]  led_o,
  output logic [RING_W-1:0] ring_o,
  output logic [3:0]        pos_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              sweep_done_o,
  output logic [SWP_W-1:0]  sweep_cnt_o
);

  localparam logic [RING_W-1:0] RING_RST = {{(RING_W-1){1'b0}}, 1'b1};
  localparam logic [SWP_W-1:0]  SWP_ONE  = {{(SWP_W-1){1'b0}}, 1'b1};

  kr_state_e         state_q, state_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic [SWP_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic              sweep_done_q, sweep_done_d;

  logic step, wrap, running, cfg_ready, accept, entry, cnt_clear;

  kr_prescaler #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_n_i    (sys_rst_i),
    .run_i      (running),
    .clear_i    (cnt_clear),
    .load_i     (accept),
    .load_div_i (cfg_div_i),
    .step_o     (step)
  );

  always_comb begin
    running   = (state_q == RUN) || (state_q == STOPPING);
    wrap      = step && ring_q[RING_W-1];
    // While stepping, the only safe moment for a new rate is the wrap step.
    cfg_ready = (state_q == IDLE) || (state_q == PAUSE) || wrap;
    accept    = cfg_valid_i && cfg_ready;

    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_i && !pause_i && !stop_i) state_d = RUN;
      RUN: begin
        if (stop_i)       state_d = wrap ? IDLE : STOPPING;
        else if (pause_i) state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_i)                 state_d = IDLE;
        else if (!pause_i && start_i) state_d = RUN;
      end
      STOPPING: if (wrap) state_d = IDLE;
    endcase

    entry     = (state_q == IDLE) && (state_d == RUN);
    cnt_clear = (state_d == IDLE);

    ring_d = ring_q;
    if (entry)     ring_d = RING_RST;
    else if (step) ring_d = {ring_q[RING_W-2:0], ring_q[RING_W-1]};

    sweep_cnt_d = sweep_cnt_q;
    if (entry) sweep_cnt_d = '0;
    else if (wrap && (sweep_cnt_q != '1)) sweep_cnt_d = sweep_cnt_q + SWP_ONE;

    sweep_done_d = wrap;
  end

  always_ff @(posedge clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q      <= IDLE;
      ring_q       <= RING_RST;
      sweep_cnt_q  <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_q       <= ring_d;
      sweep_cnt_q  <= sweep_cnt_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < RING_W; i++) begin
      if (ring_q[i]) pos_o = 4'(i);
    end
  end

  assign dir_o        = (pos_o <= 4'd6);
  assign ring_o       = ring_q;
  assign led_o        = (state_q == IDLE) ? '0 : ring_to_led(ring_q);
  assign busy_o       = (state_q != IDLE);
  assign cfg_ready_o  = cfg_ready;
  assign sweep_done_o = sweep_done_q;
  assign sweep_cnt_o  = sweep_cnt_q;

endmodule

// File: tb/tb_knight_rider_sequencer.sv
// tb/tb_knight_rider_sequencer.sv - self-checking bench for knight_rider_sequencer
module tb_knight_rider_sequencer;

  logic        clk_i = 1'b0;
  logic        sys_rst_i = 1'b0;
  logic        start_i = 1'b0, pause_i = 1'b0, stop_i = 1'b0, cfg_valid_i = 1'b0;
  logic [23:0] cfg_div_i = '0;

  logic        cfg_ready_o, dir_o, busy_o, sweep_done_o;
  logic [7:0]  led_o;
  logic [13:0] ring_o;
  logic [3:0]  pos_o;
  logic [15:0] sweep_cnt_o;

  logic        cfg_ready2, dir2, busy2, done2;
  logic [7:0]  led2;
  logic [13:0] ring2;
  logic [3:0]  pos2;
  logic [1:0]  sweep_cnt2;

  knight_rider_sequencer dut (
    .clk_i(clk_i), .sys_rst_i(sys_rst_i), .start_i(start_i), .pause_i(pause_i),
    .stop_i(stop_i), .cfg_valid_i(cfg_valid_i), .cfg_div_i(cfg_div_i),
    .cfg_ready_o(cfg_ready_o), .led_o(led_o), .ring_o(ring_o), .pos_o(pos_o),
    .dir_o(dir_o), .busy_o(busy_o), .sweep_done_o(sweep_done_o), .sweep_cnt_o(sweep_cnt_o)
  );

  knight_rider_sequencer #(.SWP_W(2)) dut2 (
    .clk_i(clk_i), .sys_rst_i(sys_rst_i), .start_i(start_i), .pause_i(pause_i),
    .stop_i(stop_i), .cfg_valid_i(cfg_valid_i), .cfg_div_i(cfg_div_i),
    .cfg_ready_o(cfg_ready2), .led_o(led2), .ring_o(ring2), .pos_o(pos2),
    .dir_o(dir2), .busy_o(busy2), .sweep_done_o(done2), .sweep_cnt_o(sweep_cnt2)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] led_seq [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                               8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 stopping; integer ring position.
  int m_mode, m_pos, m_cnt, m_div, m_sweeps;
  bit m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_step();
    int de;
    de = (m_div == 0) ? 1 : m_div;
    return (m_mode == 1 || m_mode == 3) && (m_cnt == de - 1);
  endfunction

  function automatic bit m_ready();
    return (m_mode == 0) || (m_mode == 2) || (m_step() && m_pos == 13);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0; m_div = 5_000_000; m_sweeps = 0; m_done = 0;
  endtask

  task automatic model_clock();
    bit st, wr, acc;
    int nm;
    st = m_step();
    wr = st && (m_pos == 13);
    acc = cfg_valid_i && m_ready();
    nm = m_mode;
    case (m_mode)
      0: if (start_i && !pause_i && !stop_i) nm = 1;
      1: if (stop_i) nm = wr ? 0 : 3; else if (pause_i) nm = 2;
      2: if (stop_i) nm = 0; else if (!pause_i && start_i) nm = 1;
      default: if (wr) nm = 0;
    endcase
    if (nm == 0 || acc) m_cnt = 0;
    else if (m_mode == 1 || m_mode == 3) m_cnt = st ? 0 : m_cnt + 1;
    if (m_mode == 0 && nm == 1) begin
      m_pos = 0; m_sweeps = 0;
    end else begin
      if (st) m_pos = (m_pos + 1) % 14;
      if (wr && m_sweeps < 65535) m_sweeps++;
    end
    if (acc) m_div = int'(cfg_div_i);
    m_done = wr;
    m_mode = nm;
  endtask

  task automatic compare_all();
    int li;
    li = (m_pos <= 7) ? m_pos : 14 - m_pos;
    chk("led", led_o, (m_mode == 0) ? 0 : (1 << li));
    chk("ring", ring_o, 1 << m_pos);
    chk("pos", pos_o, m_pos);
    chk("dir", dir_o, m_pos <= 6);
    chk("busy", busy_o, m_mode != 0);
    chk("sweep_done", sweep_done_o, m_done);
    chk("sweep_cnt", sweep_cnt_o, m_sweeps);
    chk("cfg_ready", cfg_ready_o, m_ready());
    chk("sweep_cnt_sat", sweep_cnt2, (m_sweeps > 3) ? 3 : m_sweeps);
  endtask

  task automatic tick(input bit s, input bit p, input bit t, input bit v, input logic [23:0] d);
    start_i = s; pause_i = p; stop_i = t; cfg_valid_i = v; cfg_div_i = d;
    model_clock();
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic run_until_pos(input int p);
    int n;
    n = 0;
    while (pos_o != 4'(p) && n < 200) begin
      tick(0, 0, 0, 0, 0);
      n++;
    end
    chk("reach_pos", pos_o, p);
  endtask

  typedef struct {
    bit s, p, t, v;
    logic [23:0] d;
    int rep;
    logic [7:0] led;
    bit busy;
    bit done;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit v, input logic [23:0] d, input int rep,
                              input logic [7:0] led, input bit busy, input bit done);
    vec_t r;
    r.s = s; r.p = 0; r.t = 0; r.v = v; r.d = d; r.rep = rep;
    r.led = led; r.busy = busy; r.done = done;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int n, pulses;
    bit v, last_acc;
    logic [23:0] d;
    logic [7:0] l0;

    // Reset state
    model_reset();
    #12;
    compare_all();
    chk("rst_led", led_o, 0);
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_dir", dir_o, 1);
    #1 sys_rst_i = 1'b1;

    // Table: program div=4 in IDLE, start, one full bounce
    tbl.push_back(mk(0, 1, 24'd4, 1, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 8'h01, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3, 8'h01, 1, 0));
    for (int k = 1; k < 14; k++) tbl.push_back(mk(0, 0, 0, 4, led_seq[k], 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h01, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3, 8'h01, 1, 0));
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        tick(tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].v, tbl[i].d);
        chk("tbl_led", led_o, tbl[i].led);
        chk("tbl_busy", busy_o, tbl[i].busy);
        chk("tbl_done", sweep_done_o, tbl[i].done);
      end
    end
    chk("first_sweep_cnt", sweep_cnt_o, 1);

    // Pause mid-interval at LED 0x10, resume keeps the remaining count
    run_until_pos(4);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 19; i++) tick(0, 1, 0, 0, 0);
    chk("pause_led", led_o, 8'h10);
    tick(1, 0, 0, 0, 0);
    n = 0;
    while (led_o == 8'h10 && n < 20) begin tick(0, 0, 0, 0, 0); n++; end
    chk("resume_len", n, 2);

    // Stop at pos 5 drains the sweep to the wrap
    run_until_pos(5);
    tick(0, 0, 1, 0, 0);
    n = 0;
    while (busy_o && n < 100) begin tick(0, 0, 0, 0, 0); n++; end
    chk("stop_drain", n, 35);
    chk("stop_ring", ring_o, 14'h0001);
    chk("stop_led", led_o, 0);

    // Stop coincident with the wrap step
    tick(1, 0, 0, 0, 0);
    n = 0;
    while (!(cfg_ready_o && busy_o) && n < 100) begin tick(0, 0, 0, 0, 0); n++; end
    chk("wrap_wait", n, 55);
    tick(0, 0, 1, 0, 0);
    chk("stop_at_wrap_busy", busy_o, 0);

    // Config request mid-run waits for the wrap step
    tick(1, 0, 0, 0, 0);
    run_until_pos(3);
    n = 0;
    while (!cfg_ready_o && n < 100) begin tick(0, 0, 0, 1, 24'd2); n++; end
    chk("cfg_accept_pos", pos_o, 13);
    tick(0, 0, 0, 1, 24'd2);
    n = 0;
    while (led_o == 8'h01 && n < 20) begin tick(0, 0, 0, 0, 0); n++; end
    chk("div2_interval", n, 2);

    // div=0 behaves as div=1
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 24'd0);
    tick(1, 0, 0, 0, 0);
    l0 = led_o;
    n = 0;
    while (led_o == l0 && n < 20) begin tick(0, 0, 0, 0, 0); n++; end
    chk("div0_interval", n, 1);

    // Asynchronous reset mid-sweep
    run_until_pos(9);
    #2 sys_rst_i = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_led", led_o, 0);
    chk("arst_busy", busy_o, 0);
    @(posedge clk_i);
    #3 sys_rst_i = 1'b1;
    tick(0, 0, 0, 1, 24'd1);
    tick(1, 0, 0, 0, 0);
    chk("restart_led", led_o, 8'h01);

    // Sweep counter saturation on the narrow build
    pulses = 0;
    for (int i = 0; i < 56; i++) begin
      tick(0, 0, 0, 0, 0);
      if (done2) pulses++;
    end
    chk("sat_pulses", pulses, 4);
    chk("sat_cnt", sweep_cnt2, 3);
    chk("full_cnt", sweep_cnt_o, 4);

    // Randomized control and config traffic against the model
    last_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cfg_valid_i && !last_acc) begin
        v = 1; d = cfg_div_i;
      end else begin
        v = ($urandom_range(0, 7) == 0);
        d = 24'($urandom_range(0, 3));
      end
      last_acc = v && cfg_ready_o;
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 24) == 0, v, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
